// File: rtl/pixel_frame_feeder_if.sv
// Host pixel stream and CNN feed bundle for pixel_frame_feeder.
// The feeder side uses the slave modport; the host/CNN side uses master.
interface pixel_frame_feeder_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] m_data;
    logic             m_valid;
    logic             cnn_busy;
    logic             frame_start;
    logic [15:0]      frames_sent;

    modport slave (
        input  s_data,
        input  s_valid,
        input  cnn_busy,
        output s_ready,
        output m_data,
        output m_valid,
        output frame_start,
        output frames_sent
    );

    modport master (
        output s_data,
        output s_valid,
        output cnn_busy,
        input  s_ready,
        input  m_data,
        input  m_valid,
        input  frame_start,
        input  frames_sent
    );
endinterface

// File: rtl/pixel_frame_feeder.sv
// Ping-pong frame buffer: collects host pixels into 784-pixel frames and
// streams each full frame to the CNN as one unbroken burst while it is idle.
module pixel_frame_feeder #(
    parameter int PIX_W        = 8,
    parameter int FRAME_PIXELS = 784,
    parameter int ADDR_W       = 10,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_frame_feeder_if.slave  bus
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int MEM_D = 2 ** (ADDR_W + 1);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [GAP_W-1:0]  LAST_G = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_GAP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [PIX_W-1:0]  r_mem [0:MEM_D-1];
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [1:0]        r_full;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_m_valid;
    logic [PIX_W-1:0]  r_m_data;
    logic              r_frame_start;
    logic [15:0]       r_frames_sent;

    logic       w_s_ready;
    logic       w_wr_en;
    logic       w_wr_last;
    logic       w_issue;
    logic       w_rd_last;
    logic [1:0] w_set;
    logic [1:0] w_clr;

    // Ready depends only on registers and reset, never on s_valid.
    assign w_s_ready = !rst && !r_full[r_wr_bank];
    assign w_wr_en   = bus.s_valid && w_s_ready;
    assign w_wr_last = w_wr_en && (r_wr_cnt == LAST_A);

    assign w_set = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr = w_rd_last ? (2'b01 << r_rd_bank) : 2'b00;

    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_rd_last = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank] && !bus.cnn_busy) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                w_issue = 1'b1;
                if (r_rd_cnt == LAST_A) begin
                    w_rd_last = 1'b1;
                    w_next    = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == LAST_G) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
        end else if (w_wr_en) begin
            if (w_wr_last) begin
                r_wr_cnt  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
        end
    end

    // A release and a fill can land in the same cycle on opposite banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_set) & ~w_clr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_bank <= 1'b0;
            r_rd_cnt  <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
            end else if (r_state == S_IDLE) begin
                r_rd_cnt <= '0;
            end
            if (w_rd_last) begin
                r_rd_bank <= ~r_rd_bank;
            end
            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    // Bank storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wr_bank, r_wr_cnt}] <= bus.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_frame_start <= 1'b0;
            r_frames_sent <= '0;
        end else begin
            r_m_valid     <= w_issue;
            r_frame_start <= w_issue && (r_rd_cnt == '0);
            if (w_issue) begin
                r_m_data <= r_mem[{r_rd_bank, r_rd_cnt}];
            end
            if (w_rd_last) begin
                r_frames_sent <= r_frames_sent + 16'd1;
            end
        end
    end

    assign bus.s_ready     = w_s_ready;
    assign bus.m_valid     = r_m_valid;
    assign bus.m_data      = r_m_data;
    assign bus.frame_start = r_frame_start;
    assign bus.frames_sent = r_frames_sent;
endmodule
